// File: rtl/switch_sampler_if.sv
// Snapshot handshake bundle between the switch conditioner and its consumer.
// The producer drives data/valid/status and the consumer drives ready.
interface switch_sampler_if #(
  parameter int WIDTH = 5
);
  logic [WIDTH-1:0] o;
  logic [WIDTH-1:0] changed;
  logic             valid;
  logic             ready;
  logic             overrun;

  modport master (
    output o,
    output changed,
    output valid,
    output overrun,
    input  ready
  );

  modport slave (
    input  o,
    input  changed,
    input  valid,
    input  overrun,
    output ready
  );
endinterface

// File: rtl/switch_sampler.sv
// DIP switch conditioner: 2-flop sync, per-bit debounce, change detect,
// and a valid/ready snapshot offer with sticky overrun on merged changes.
module switch_sampler #(
  parameter int WIDTH           = 5,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] switches,
  switch_sampler_if.master bus
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] stable;
  logic [CW-1:0]    cnt [WIDTH];

  logic [WIDTH-1:0] ev;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] diff;

  logic [WIDTH-1:0] o_q;
  logic [WIDTH-1:0] changed_q;
  logic             valid_q;
  logic             overrun_q;

  logic             ready;
  logic             take;

  assign ready = bus.ready;

  // Event only when a bit has disagreed for the full window.
  always_comb begin
    diff = s2 ^ stable;
    ev   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ev[i] = diff[i] && (cnt[i] == CNT_MAX);
    end
    nxt  = stable ^ ev;
    take = !valid_q || ready;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1     <= '0;
      s2     <= '0;
      stable <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1     <= switches;
      s2     <= s1;
      stable <= nxt;
      for (int i = 0; i < WIDTH; i++) begin
        if (!diff[i] || ev[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      o_q       <= '0;
      changed_q <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (|ev) begin
        o_q     <= nxt;
        valid_q <= 1'b1;
        if (take) begin
          changed_q <= ev;
        end else begin
          // Consumer still holds the old snapshot: fold the new bits in.
          changed_q <= changed_q | ev;
          overrun_q <= 1'b1;
        end
      end else if (valid_q && ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.o       = o_q;
  assign bus.changed = changed_q;
  assign bus.valid   = valid_q;
  assign bus.overrun = overrun_q;

endmodule
